// File: rtl/cpu_types.sv
// ============================================================================
// cpu_types : packet types shared by the execute / memory_access pipeline.
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } mem_data_t;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] pc;
        logic [31:0] instr;
        mem_data_t   data;
    } stage_status_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid_register_if.sv
// ============================================================================
// ex_mem_skid_register_if : execute -> memory_access pipeline register bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface ex_mem_skid_register_if;
    import cpu_types::*;

    stage_status_t stage_in;
    logic          upstream_ready;
    stage_status_t stage_out;
    logic          downstream_ready;
    logic          flush;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cycles;

    modport master (
        output stage_in,
        input  upstream_ready,
        input  stage_out,
        output downstream_ready,
        output flush,
        input  occupancy,
        input  stall_cycles
    );

    modport slave (
        input  stage_in,
        output upstream_ready,
        output stage_out,
        input  downstream_ready,
        input  flush,
        output occupancy,
        output stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/ex_mem_skid_register.sv
// ============================================================================
// ex_mem_skid_register : two-entry (head + skid) pipeline register between
// execute and memory_access, with flush and a saturating stall counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_mem_skid_register
    import cpu_types::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    ex_mem_skid_register_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Only payload fields are stored; valid/ready are regenerated from state.
    logic [31:0] h_pc_q,    h_pc_d;
    logic [31:0] h_instr_q, h_instr_d;
    mem_data_t   h_data_q,  h_data_d;
    logic [31:0] s_pc_q,    s_pc_d;
    logic [31:0] s_instr_q, s_instr_d;
    mem_data_t   s_data_q,  s_data_d;
    logic [31:0] stall_q,   stall_d;

    logic w_upstream_ready;
    logic w_head_valid;
    logic w_in_fire;
    logic w_out_fire;

    // Ready depends only on registered state, never on downstream_ready.
    assign w_upstream_ready = (state_q != FULL);
    assign w_head_valid     = (state_q != EMPTY);
    assign w_in_fire        = bus.stage_in.valid && w_upstream_ready;
    assign w_out_fire       = w_head_valid && bus.downstream_ready;

    always_comb begin
        state_d   = state_q;
        h_pc_d    = h_pc_q;
        h_instr_d = h_instr_q;
        h_data_d  = h_data_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;
        s_data_d  = s_data_q;

        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_in_fire) begin
                        h_pc_d    = bus.stage_in.pc;
                        h_instr_d = bus.stage_in.instr;
                        h_data_d  = bus.stage_in.data;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        h_pc_d    = bus.stage_in.pc;
                        h_instr_d = bus.stage_in.instr;
                        h_data_d  = bus.stage_in.data;
                    end else if (w_in_fire) begin
                        s_pc_d    = bus.stage_in.pc;
                        s_instr_d = bus.stage_in.instr;
                        s_data_d  = bus.stage_in.data;
                        state_d   = FULL;
                    end else if (w_out_fire) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        h_pc_d    = s_pc_q;
                        h_instr_d = s_instr_q;
                        h_data_d  = s_data_q;
                        state_d   = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (w_head_valid && !bus.downstream_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            h_pc_q    <= '0;
            h_instr_q <= '0;
            h_data_q  <= '0;
            s_pc_q    <= '0;
            s_instr_q <= '0;
            s_data_q  <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            h_pc_q    <= h_pc_d;
            h_instr_q <= h_instr_d;
            h_data_q  <= h_data_d;
            s_pc_q    <= s_pc_d;
            s_instr_q <= s_instr_d;
            s_data_q  <= s_data_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        bus.stage_out.valid      = w_head_valid;
        bus.stage_out.ready      = w_upstream_ready;
        bus.stage_out.pc         = h_pc_q;
        bus.stage_out.instr      = h_instr_q;
        bus.stage_out.data.valid = h_data_q.valid && w_head_valid;
        bus.stage_out.data.data  = h_data_q.data;
    end

    assign bus.upstream_ready = w_upstream_ready;
    assign bus.occupancy      = state_q;
    assign bus.stall_cycles   = stall_q;

endmodule

`default_nettype wire
